// File: rtl/stepper_ctrl.sv
// Stepper motor controller: synchronised step input, half/full/wave phase table, PWM current reference.
// Optional idle hold-current reduction enabled with `define STEPPER_HOLD_CURRENT_EN.
module stepper_ctrl #(
    parameter int               PWM_W       = 4,
    parameter int               POS_W       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter int               HOLD_CYCLES = 1000000,
    parameter logic [PWM_W-1:0] HOLD_LEVEL  = PWM_W'(4)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_pulse,
    input  logic                    direction,
    input  logic                    module_enable,
    input  logic [1:0]              mode,
    input  logic [PWM_W-1:0]        vref_level,
    input  logic                    pos_clear,
    output logic                    INA1,
    output logic                    INA2,
    output logic                    INB1,
    output logic                    INB2,
    output logic                    STANBY,
    output logic                    VREF_PWM,
    output logic signed [POS_W-1:0] position,
    output logic                    hold_active
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [2:0]             idx_q, idx_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic [PWM_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             br_q, br_d;
    logic                   pwm_q, pwm_d;
    logic                   accept;
    logic [2:0]             delta;
    logic [PWM_W-1:0]       eff_level;
    logic                   hold;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], step_pulse};
        edge_d = sync_q[SYNC_STAGES-1];
        accept = sync_q[SYNC_STAGES-1] & ~edge_q & module_enable;

        // Full-step lands on odd indices, wave on even; a mismatch realigns by one.
        unique case (mode)
            2'd1:    delta = idx_q[0] ? 3'd2 : 3'd1;
            2'd2:    delta = idx_q[0] ? 3'd1 : 3'd2;
            default: delta = 3'd1;
        endcase

        idx_d = idx_q;
        if (accept) begin
            idx_d = direction ? idx_q + delta : idx_q - delta;
        end

        pos_d = pos_q;
        if (pos_clear) begin
            pos_d = '0;
        end else if (accept) begin
            pos_d = direction ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end

        br_d = 4'b0000;
        if (module_enable) begin
            unique case (idx_q)
                3'd0:    br_d = 4'b1000;
                3'd1:    br_d = 4'b1010;
                3'd2:    br_d = 4'b0010;
                3'd3:    br_d = 4'b0110;
                3'd4:    br_d = 4'b0100;
                3'd5:    br_d = 4'b0101;
                3'd6:    br_d = 4'b0001;
                default: br_d = 4'b1001;
            endcase
        end

        cnt_d = cnt_q + PWM_W'(1);
        pwm_d = (cnt_q < eff_level) & module_enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            idx_q  <= '0;
            pos_q  <= '0;
            cnt_q  <= '0;
            br_q   <= '0;
            pwm_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
            idx_q  <= idx_d;
            pos_q  <= pos_d;
            cnt_q  <= cnt_d;
            br_q   <= br_d;
            pwm_q  <= pwm_d;
        end
    end

`ifdef STEPPER_HOLD_CURRENT_EN
    localparam int IDLE_W = $clog2(HOLD_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Saturates at HOLD_CYCLES so hold stays asserted until the next step.
    always_comb begin
        hold   = (idle_q == IDLE_W'(HOLD_CYCLES));
        idle_d = idle_q;
        if (accept) begin
            idle_d = '0;
        end else if (!hold) begin
            idle_d = idle_q + IDLE_W'(1);
        end
        eff_level = (hold && (vref_level > HOLD_LEVEL)) ? HOLD_LEVEL : vref_level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_hold;

    assign hold        = 1'b0;
    assign eff_level   = vref_level;
    assign unused_hold = ^{HOLD_LEVEL, 32'(HOLD_CYCLES)};
`endif

    assign {INA1, INA2, INB1, INB2} = br_q;
    assign STANBY      = module_enable;
    assign VREF_PWM    = pwm_q;
    assign position    = pos_q;
    assign hold_active = hold;

endmodule

// File: tb/tb_stepper_ctrl.sv
// Self-checking bench for stepper_ctrl: directed scenarios plus random steps
// compared against a behavioural phase/position model.
module tb_stepper_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_pulse = 1'b1;
    logic       direction = 1'b1;
    logic       module_enable = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [3:0] vref_level = 4'd5;
    logic       pos_clear = 1'b0;
    logic       INA1, INA2, INB1, INB2, STANBY, VREF_PWM, hold_active;
    logic [7:0] position;
    wire  [3:0] br = {INA1, INA2, INB1, INB2};

    int checks = 0;
    int errors = 0;
    int m_idx = 0;
    int m_pos = 0;
    int n;
    logic [3:0] old_br, new_br;

    stepper_ctrl #(
        .PWM_W(4), .POS_W(8), .SYNC_STAGES(2),
        .HOLD_CYCLES(100), .HOLD_LEVEL(4'd4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .step_pulse(step_pulse),
        .direction(direction), .module_enable(module_enable),
        .mode(mode), .vref_level(vref_level), .pos_clear(pos_clear),
        .INA1(INA1), .INA2(INA2), .INB1(INB1), .INB2(INB2),
        .STANBY(STANBY), .VREF_PWM(VREF_PWM), .position(position),
        .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Coil polarity per phase: +1 = x1 high, -1 = x2 high, 0 = off.
    function automatic logic [3:0] phase(input int i);
        int a[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
        int b[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        return {a[i] > 0, a[i] < 0, b[i] > 0, b[i] < 0};
    endfunction

    task automatic model_step();
        int d;
        if (!module_enable) begin
            if (pos_clear) m_pos = 0;
            return;
        end
        d = 1;
        if (mode == 2'd1 && (m_idx % 2) == 1) d = 2;
        if (mode == 2'd2 && (m_idx % 2) == 0) d = 2;
        m_idx = direction ? (m_idx + d) % 8 : (m_idx + 8 - d) % 8;
        if (pos_clear) begin
            m_pos = 0;
        end else begin
            m_pos = m_pos + (direction ? 1 : -1);
            if (m_pos > 127) m_pos -= 256;
            if (m_pos < -128) m_pos += 256;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".in"}, 32'(br), module_enable ? 32'(phase(m_idx)) : 32'd0);
        check({tag, ".pos"}, 32'(position), 32'(m_pos & 255));
    endtask

    task automatic do_step();
        @(negedge clk) step_pulse = 1'b1;
        repeat (4) @(negedge clk);
        step_pulse = 1'b0;
        repeat (4) @(negedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_idx = 0;
        m_pos = 0;
    endtask

    task automatic pwm_count(output int cnt);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            cnt += int'(VREF_PWM);
        end
    endtask

    initial begin
        // Reset values, with step_pulse already high at release.
        repeat (3) @(negedge clk);
        check("rst.in", 32'(br), 32'd0);
        check("rst.pos", 32'(position), 32'd0);
        check("rst.pwm", 32'(VREF_PWM), 32'd0);
        check("rst.hold", 32'(hold_active), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        model_step();
        check_state("rel_high");
        step_pulse = 1'b0;
        repeat (6) @(negedge clk);
        check_state("rel_once");

        // Nine half-steps forward.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_step();
            check_state("half");
        end
        check("half9.in", 32'(br), 32'b1010);
        check("half9.pos", 32'(position), 32'd9);

        // Full-step and wave realignment.
        do_reset();
        mode = 2'd1;
        repeat (3) do_step();
        check("full.in", 32'(br), 32'(phase(5)));
        mode = 2'd2;
        do_step();
        check("wave.in", 32'(br), 32'b0001);
        direction = 1'b0;
        do_step();
        check("wave_rev.in", 32'(br), 32'b0100);
        check_state("wave_rev");

        // Latency: IN* must change on the fourth edge after the rise.
        mode = 2'd0;
        direction = 1'b1;
        old_br = br;
        new_br = phase((m_idx + 1) % 8);
        @(negedge clk) step_pulse = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_e%0d", e), 32'(br),
                  (e < 4) ? 32'(old_br) : 32'(new_br));
        end
        @(negedge clk) step_pulse = 1'b0;
        repeat (4) @(negedge clk);
        model_step();
        check_state("lat");

        // PWM duty right after a step so no hold reduction applies.
        do_step();
        vref_level = 4'd5;
        repeat (2) @(negedge clk);
        pwm_count(n);
        check("pwm5", 32'(n), 32'd5);
        vref_level = 4'd0;
        repeat (2) @(negedge clk);
        pwm_count(n);
        check("pwm0", 32'(n), 32'd0);
        vref_level = 4'd15;
        repeat (2) @(negedge clk);
        pwm_count(n);
        check("pwm15", 32'(n), 32'd15);

        // Disabled driver: outputs low, steps ignored.
        module_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("dis.stanby", 32'(STANBY), 32'd0);
        pwm_count(n);
        check("dis.pwm", 32'(n), 32'd0);
        do_step();
        check_state("dis");
        module_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("en.stanby", 32'(STANBY), 32'd1);
        check_state("reen");

        // Position wrap and clear-with-step.
        do_reset();
        repeat (127) do_step();
        check("pos127", 32'(position), 32'd127);
        do_step();
        check("pos_wrap", 32'(position), 32'h80);
        check_state("wrap");
        pos_clear = 1'b1;
        do_step();
        pos_clear = 1'b0;
        check("clr.pos", 32'(position), 32'd0);
        check_state("clr_step");

        // Reset while an edge is inside the synchroniser.
        @(negedge clk) step_pulse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        step_pulse = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_idx = 0;
        m_pos = 0;
        repeat (8) @(negedge clk);
        check_state("midrst");

        // Random steps against the model.
        for (int i = 0; i < 40; i++) begin
            direction = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            module_enable = ($urandom_range(0, 4) != 0);
            pos_clear = ($urandom_range(0, 5) == 0);
            repeat (2) @(negedge clk);
            do_step();
            pos_clear = 1'b0;
            check_state($sformatf("rnd%0d", i));
        end
        module_enable = 1'b1;

        // Idle hold current.
        vref_level = 4'd12;
        do_step();
        check("hold.after_step", 32'(hold_active), 32'd0);
        repeat (80) @(negedge clk);
        check("hold.early", 32'(hold_active), 32'd0);
`ifdef STEPPER_HOLD_CURRENT_EN
        repeat (30) @(negedge clk);
        check("hold.on", 32'(hold_active), 32'd1);
        pwm_count(n);
        check("hold.pwm", 32'(n), 32'd4);
        do_step();
        check("hold.off", 32'(hold_active), 32'd0);
        pwm_count(n);
        check("hold.pwm_full", 32'(n), 32'd12);
`else
        repeat (30) @(negedge clk);
        check("nohold", 32'(hold_active), 32'd0);
        pwm_count(n);
        check("nohold.pwm", 32'(n), 32'd12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
